wb_host_bridge: RTL and testbench

Wishbone classic-cycle master (initiator) that turns single commands from a valid/ready command port into one Wishbone read or write, then returns the result on a valid/ready response port. It sits on the initiator side of the user-area Wishbone bus and drives slaves such as the project counter from logic-analyzer probes or an on-chip sequencer. It enforces a bounded wait and reports a timeout error when a slave never acknowledges.

---
 rtl/wb_host_bridge.sv | 114 +++++++++++
 tb/tb_wb_host_bridge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_host_bridge.sv
// rtl/wb_host_bridge.sv - Wishbone classic-cycle master driven by a valid/ready command port
module wb_host_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Last counter value before the abort fires; the abort edge is TIMEOUT cycles after accept.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_cyc;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [31:0] r_rdat;
  logic        r_err;

  // Handshake and status flags are decoded from state only, so no input reaches an output combinationally.
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_dat   = r_rdat;
  assign rsp_err   = r_err;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_wdat;

  // Command accept, bus cycle with bounded wait, and response hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_sel   <= 4'd0;
      r_adr   <= 32'd0;
      r_wdat  <= 32'd0;
      r_rdat  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_we    <= cmd_we;
            r_sel   <= cmd_sel;
            r_adr   <= cmd_adr;
            r_wdat  <= cmd_dat;
            r_cyc   <= 1'b1;
            r_cnt   <= 16'd0;
            r_state <= S_BUS;
          end
        end
        S_BUS: begin
          // ACK takes priority over a timeout landing on the same edge.
          if (wbm_ack_i) begin
            r_cyc   <= 1'b0;
            r_rdat  <= r_we ? 32'd0 : wbm_dat_i;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (r_cnt == TO_LAST) begin
            r_cyc   <= 1'b0;
            r_rdat  <= 32'hFFFF_FFFF;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cyc   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_bridge.sv
// tb/tb_wb_host_bridge.sv - directed self-checking bench for wb_host_bridge
module tb_wb_host_bridge;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy;

  int checks;
  int failures;
  int stb_cycles;
  int d;

  wb_host_bridge #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_sel   (cmd_sel),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (wbm_stb_o) stb_cycles++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0; stb_cycles = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = 4'd0;
    cmd_adr = 32'd0; cmd_dat = 32'd0; rsp_ready = 1'b0;
    wbm_ack_i = 1'b0; wbm_dat_i = 32'd0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err",   rsp_err, 0);
    check("rst_rsp_dat",   rsp_dat, 0);
    check("rst_cyc",       wbm_cyc_o, 0);
    check("rst_busy",      busy, 0);
    check("rst_adr",       wbm_adr_o, 0);

    // write, slave acks after E1
    stb_cycles = 0;
    cmd_valid = 1; cmd_we = 1; cmd_sel = 4'b0011; cmd_adr = 32'h3000_0000; cmd_dat = 32'h0000_1234;
    tick();                           // E0
    cmd_valid = 0;
    check("wr_cyc_e0",   wbm_cyc_o, 1);
    check("wr_stb_e0",   wbm_stb_o, 1);
    check("wr_we",       wbm_we_o, 1);
    check("wr_sel",      wbm_sel_o, 4'b0011);
    check("wr_adr",      wbm_adr_o, 32'h3000_0000);
    check("wr_dat",      wbm_dat_o, 32'h0000_1234);
    check("wr_cmd_ready", cmd_ready, 0);
    check("wr_busy",     busy, 1);
    tick();                           // E1
    check("wr_cyc_e1",   wbm_cyc_o, 1);
    check("wr_rsp_e1",   rsp_valid, 0);
    wbm_ack_i = 1; wbm_dat_i = 32'hDEAD_BEEF;
    tick();                           // E2
    wbm_ack_i = 0;
    check("wr_cyc_e2",   wbm_cyc_o, 0);
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_dat",  rsp_dat, 0);
    check("wr_rsp_err",  rsp_err, 0);
    check("wr_stb_win",  stb_cycles, 2);
    check("wr_we_retain", wbm_we_o, 1);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("wr_done_valid", rsp_valid, 0);
    check("wr_done_ready", cmd_ready, 1);

    // read with a stalled consumer
    cmd_valid = 1; cmd_we = 0; cmd_sel = 4'b1111; cmd_adr = 32'h3000_0000;
    tick();
    cmd_valid = 0;
    check("rd_we", wbm_we_o, 0);
    tick();
    wbm_ack_i = 1; wbm_dat_i = 32'h0000_00A5;
    tick();
    wbm_ack_i = 0; wbm_dat_i = 32'h0;
    check("rd_rsp_dat", rsp_dat, 32'h0000_00A5);
    check("rd_rsp_err", rsp_err, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rd_hold_valid", rsp_valid, 1);
      check("rd_hold_dat",   rsp_dat, 32'h0000_00A5);
      check("rd_hold_busy",  busy, 1);
      check("rd_hold_cmdrdy", cmd_ready, 0);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("rd_done_valid", rsp_valid, 0);

    // timeout: no ack, abort on the 8th edge after accept
    cmd_valid = 1; cmd_adr = 32'h3000_0004;
    tick();
    cmd_valid = 0;
    for (int i = 1; i < 8; i++) begin
      tick();
      check("to_cyc_held", wbm_cyc_o, 1);
      check("to_no_rsp",   rsp_valid, 0);
    end
    tick();
    check("to_cyc_drop", wbm_cyc_o, 0);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err",  rsp_err, 1);
    check("to_rsp_dat",  rsp_dat, 32'hFFFF_FFFF);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // ack coincides with the timeout edge: ack wins
    cmd_valid = 1;
    tick();
    cmd_valid = 0;
    for (int i = 1; i < 8; i++) tick();
    check("tie_cyc_before", wbm_cyc_o, 1);
    wbm_ack_i = 1; wbm_dat_i = 32'h0000_0055;
    tick();
    wbm_ack_i = 0;
    check("tie_rsp_valid", rsp_valid, 1);
    check("tie_rsp_err",   rsp_err, 0);
    check("tie_rsp_dat",   rsp_dat, 32'h0000_0055);
    rsp_ready = 1;
    tick();

    // back-to-back reads, cmd_valid and rsp_ready held high
    cmd_valid = 1; cmd_we = 0;
    for (int n = 0; n < 4; n++) begin
      cmd_adr = 32'h3000_0100 + 32'(n * 4);
      check("b2b_ready", cmd_ready, 1);
      stb_cycles = 0;
      tick();                         // accept
      check("b2b_adr", wbm_adr_o, 32'h3000_0100 + 32'(n * 4));
      d = int'($urandom_range(0, 3));
      for (int k = 0; k < d; k++) begin
        tick();
        check("b2b_wait_cyc", wbm_cyc_o, 1);
        check("b2b_wait_ready", cmd_ready, 0);
      end
      wbm_ack_i = 1; wbm_dat_i = 32'h0000_0100 + 32'(n);
      tick();
      wbm_ack_i = 0;
      check("b2b_rsp_valid", rsp_valid, 1);
      check("b2b_rsp_dat",   rsp_dat, 32'h0000_0100 + 32'(n));
      check("b2b_one_win",   stb_cycles, 32'(d + 1));
      check("b2b_outstanding", cmd_ready, 0);
      tick();                         // handshake
      check("b2b_rsp_clear", rsp_valid, 0);
    end
    cmd_valid = 0; rsp_ready = 0;

    // reset during a stalled read
    cmd_valid = 1; cmd_adr = 32'h3000_0200;
    tick();
    cmd_valid = 0;
    tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    check("rst_bus_cyc",   wbm_cyc_o, 0);
    check("rst_bus_valid", rsp_valid, 0);
    check("rst_bus_ready", cmd_ready, 1);
    check("rst_bus_adr",   wbm_adr_o, 0);
    wbm_ack_i = 1; wbm_dat_i = 32'h1111_1111;
    tick();
    wbm_ack_i = 0;
    tick();
    check("rst_late_valid", rsp_valid, 0);
    check("rst_late_cyc",   wbm_cyc_o, 0);
    check("rst_late_busy",  busy, 0);

    // stray ack in IDLE
    wbm_ack_i = 1; wbm_dat_i = 32'h2222_2222;
    tick();
    wbm_ack_i = 0;
    check("idle_ack_valid", rsp_valid, 0);
    check("idle_ack_ready", cmd_ready, 1);
    check("idle_ack_dat",   rsp_dat, 0);

    // stray ack in RESP
    cmd_valid = 1; cmd_adr = 32'h3000_0300;
    tick();
    cmd_valid = 0;
    wbm_ack_i = 1; wbm_dat_i = 32'h0000_0077;
    tick();
    check("resp_first_dat", rsp_dat, 32'h0000_0077);
    wbm_dat_i = 32'h0000_0099;
    tick();
    wbm_ack_i = 0;
    check("resp_ack_valid", rsp_valid, 1);
    check("resp_ack_dat",   rsp_dat, 32'h0000_0077);
    check("resp_ack_cyc",   wbm_cyc_o, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("resp_done", cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
